hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 16-bit five-stage core. It tracks destination registers of instructions in flight and drives operand bypass selects (Bypass_MUX). It sequences load-use stalls, branch-mispredict flushes (Flush_MUX, Instr_MUX jump squash) and full-pipeline freezes on D-cache miss. It sits beside the ID stage, sees ID operands and EX/MEM status, and returns stall/flush/select controls to every stage.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_scoreboard.sv | 72 +++++++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg: shared encodings for the pipeline hazard controller.
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [1:0]  BYP_RF    = 2'b00;
  localparam logic [1:0]  BYP_EXMEM = 2'b01;
  localparam logic [1:0]  BYP_MEMWB = 2'b10;
  localparam logic [15:0] NOP       = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DMISS = 2'd3
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard: EX/MEM/WB destination tracker with bypass and load-use match.
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             kill_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_wr_i,
  input  logic             id_load_i,
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_src1_used_i,
  input  logic             id_src2_used_i,
  output logic [1:0]       byp_sel1_o,
  output logic [1:0]       byp_sel2_o,
  output logic             load_use_o
);

  // Index 0 = EX, 1 = MEM, 2 = WB. Invalid slots are stored as all-zero.
  logic [REG_W-1:0] dst_q [3];
  logic             wr_q  [3];
  logic             ld_q  [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        dst_q[i] <= '0;
        wr_q[i]  <= 1'b0;
        ld_q[i]  <= 1'b0;
      end
    end else if (shift_en_i) begin
      for (int i = 2; i > 0; i--) begin
        dst_q[i] <= dst_q[i-1];
        wr_q[i]  <= wr_q[i-1];
        ld_q[i]  <= ld_q[i-1];
      end
      dst_q[0] <= kill_i ? '0 : id_dst_i;
      wr_q[0]  <= id_wr_i & ~kill_i;
      ld_q[0]  <= id_load_i & ~kill_i;
    end
  end

  function automatic logic [1:0] sel_for(input logic used, input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = BYP_RF;
    if (used && (src != '0)) begin
      if (wr_q[0] && !ld_q[0] && (dst_q[0] == src))
        sel = BYP_EXMEM;
      else if (wr_q[1] && (dst_q[1] == src))
        sel = BYP_MEMWB;
    end
    return sel;
  endfunction

  function automatic logic lu_for(input logic used, input logic [REG_W-1:0] src);
    return used && (src != '0) && ld_q[0] && (dst_q[0] == src);
  endfunction

  assign byp_sel1_o = sel_for(id_src1_used_i, id_src1_i);
  assign byp_sel2_o = sel_for(id_src2_used_i, id_src2_i);
  assign load_use_o = lu_for(id_src1_used_i, id_src1_i) | lu_for(id_src2_used_i, id_src2_i);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl: stall / flush / freeze sequencing and operand bypass selects.
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_src1_used_i,
  input  logic             id_src2_used_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_wr_i,
  input  logic             id_load_i,
  input  logic             br_miss_i,
  input  logic             d_miss_i,
  output logic [1:0]       byp_sel1_o,
  output logic [1:0]       byp_sel2_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_bubble_o,
  output logic             flush_o,
  output logic             freeze_o
);

  localparam logic [1:0] FC    = 2'(FLUSH_CYCLES);
  localparam logic [1:0] FC_M1 = 2'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       load_use;

  hazard_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk            (clk),
    .rst            (rst),
    .shift_en_i     (~freeze_o),
    .kill_i         (idex_bubble_o | flush_o),
    .id_dst_i       (id_dst_i),
    .id_wr_i        (id_wr_i),
    .id_load_i      (id_load_i),
    .id_src1_i      (id_src1_i),
    .id_src2_i      (id_src2_i),
    .id_src1_used_i (id_src1_used_i),
    .id_src2_used_i (id_src2_used_i),
    .byp_sel1_o     (byp_sel1_o),
    .byp_sel2_o     (byp_sel2_o),
    .load_use_o     (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    idex_bubble_o = 1'b0;
    flush_o       = 1'b0;
    freeze_o      = 1'b0;

    if (d_miss_i || (state_q == ST_DMISS)) begin
      freeze_o     = 1'b1;
      pc_stall_o   = 1'b1;
      ifid_stall_o = 1'b1;
      if (d_miss_i) begin
        // A squash interrupted by the miss is owed again in full afterwards.
        state_d = ST_DMISS;
        cnt_d   = '0;
        pend_d  = pend_q | br_miss_i | (state_q == ST_FLUSH);
      end else begin
        state_d = (pend_q || br_miss_i) ? ST_FLUSH : ST_RUN;
        cnt_d   = (pend_q || br_miss_i) ? FC : 2'd0;
        pend_d  = 1'b0;
      end
    end else if (br_miss_i) begin
      flush_o       = 1'b1;
      idex_bubble_o = 1'b1;
      cnt_d         = FC_M1;
      state_d       = (FC_M1 != 2'd0) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      flush_o       = 1'b1;
      idex_bubble_o = 1'b1;
      cnt_d         = cnt_q - 2'd1;
      state_d       = (cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
    end else if (load_use) begin
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
      state_d       = ST_LU;
    end else begin
      state_d = ST_RUN;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl: directed and random checks against a behavioural model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src1 = '0, src2 = '0, dst = '0;
  logic       u1 = 0, u2 = 0, wr = 0, ld = 0, br = 0, dm = 0;
  logic [1:0] byp1, byp2;
  logic       pc_stall, ifid_stall, idex_bubble, flush, freeze;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .id_src1_i(src1), .id_src2_i(src2),
    .id_src1_used_i(u1), .id_src2_used_i(u2),
    .id_dst_i(dst), .id_wr_i(wr), .id_load_i(ld),
    .br_miss_i(br), .d_miss_i(dm),
    .byp_sel1_o(byp1), .byp_sel2_o(byp2),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall),
    .idex_bubble_o(idex_bubble), .flush_o(flush), .freeze_o(freeze)
  );

  always #5 clk = ~clk;

  // Model: pipeline slots as {dst, writes, load}; [0]=EX, [1]=MEM, [2]=WB.
  int m_dst [3];
  bit m_wr  [3];
  bit m_ld  [3];
  int flush_left;   // flush cycles still owed after the current one
  bit hold;         // freeze continues one cycle after d_miss drops
  bit owed;         // branch flush owed once the freeze ends

  int e_b1, e_b2;
  bit e_pc, e_if, e_bub, e_fl, e_fz;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_dst[i] = 0; m_wr[i] = 0; m_ld[i] = 0; end
    flush_left = 0; hold = 0; owed = 0;
  endtask

  function automatic int exp_sel(bit used, int src);
    if (!used || src == 0) return 0;
    if (m_wr[0] && !m_ld[0] && m_dst[0] == src) return 1;
    if (m_wr[1] && m_dst[1] == src) return 2;
    return 0;
  endfunction

  function automatic bit exp_lu();
    return (u1 && src1 != 0 && m_ld[0] && m_dst[0] == int'(src1)) ||
           (u2 && src2 != 0 && m_ld[0] && m_dst[0] == int'(src2));
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compute_expect();
    e_b1 = exp_sel(u1, int'(src1));
    e_b2 = exp_sel(u2, int'(src2));
    e_pc = 0; e_if = 0; e_bub = 0; e_fl = 0; e_fz = 0;
    if (dm || hold) begin
      e_fz = 1; e_pc = 1; e_if = 1;
    end else if (br || flush_left > 0) begin
      e_fl = 1; e_bub = 1;
    end else if (exp_lu()) begin
      e_pc = 1; e_if = 1; e_bub = 1;
    end
  endtask

  task automatic compare_all();
    compute_expect();
    check("byp_sel1", byp1, e_b1);
    check("byp_sel2", byp2, e_b2);
    check("pc_stall", pc_stall, e_pc);
    check("ifid_stall", ifid_stall, e_if);
    check("idex_bubble", idex_bubble, e_bub);
    check("flush", flush, e_fl);
    check("freeze", freeze, e_fz);
  endtask

  // Apply one cycle's ID/EX/MEM inputs and check the combinational response.
  task automatic drive(int s1, bit uu1, int s2, bit uu2, int d, bit w, bit l, bit b, bit m);
    src1 = 4'(s1); u1 = uu1; src2 = 4'(s2); u2 = uu2;
    dst = 4'(d); wr = w; ld = l; br = b; dm = m;
    #2;
    compare_all();
  endtask

  // Clock edge: advance the model with the inputs that were present.
  task automatic adv();
    compute_expect();
    @(posedge clk);
    if (e_fz) begin
      if (dm) begin
        owed = owed | br | (flush_left > 0);
        flush_left = 0;
      end else begin
        flush_left = (owed || br) ? FC : 0;
        owed = 0;
      end
      hold = dm;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_dst[i] = m_dst[i-1]; m_wr[i] = m_wr[i-1]; m_ld[i] = m_ld[i-1];
      end
      if (e_fl || e_bub) begin
        m_dst[0] = 0; m_wr[0] = 0; m_ld[0] = 0;
      end else begin
        m_dst[0] = int'(dst); m_wr[0] = wr; m_ld[0] = ld;
      end
      if (br) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
    end
    #1;
  endtask

  initial begin
    int dm_left;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_flush", flush, 0);
    check("rst_freeze", freeze, 0);
    check("rst_byp1", byp1, 0);
    adv();

    // ALU back-to-back on r3
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0); adv();
    drive(3, 1, 0, 0, 4, 1, 0, 0, 0);
    check("alu_ex_byp1", byp1, 1);
    check("alu_ex_nostall", pc_stall, 0);
    adv();
    drive(0, 0, 3, 1, 0, 0, 0, 0, 0);
    check("alu_mem_byp2", byp2, 2);
    adv();

    // Load-use on r5
    drive(0, 0, 0, 0, 5, 1, 1, 0, 0); adv();
    drive(0, 0, 5, 1, 6, 1, 0, 0, 0);
    check("lu_pc_stall", pc_stall, 1);
    check("lu_bubble", idex_bubble, 1);
    adv();
    drive(0, 0, 5, 1, 6, 1, 0, 0, 0);
    check("lu_after_byp2", byp2, 2);
    check("lu_after_nostall", pc_stall, 0);
    adv();

    // r0 and unused sources
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("r0_byp1", byp1, 0);
    adv();
    drive(0, 0, 0, 0, 6, 1, 1, 0, 0); adv();
    drive(6, 0, 6, 0, 0, 0, 0, 0, 0);
    check("unused_byp1", byp1, 0);
    check("unused_nostall", pc_stall, 0);
    adv();

    // Branch mispredict: squashed instruction must not bypass
    drive(0, 0, 0, 0, 7, 1, 0, 1, 0);
    check("br_flush0", flush, 1);
    adv();
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0);
    check("br_flush1", flush, 1);
    check("br_squash_byp1", byp1, 0);
    adv();
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0);
    check("br_flush_end", flush, 0);
    adv();

    // D-miss 4 cycles with br_miss in the first
    drive(0, 0, 0, 0, 8, 1, 0, 0, 0); adv();
    for (int i = 0; i < 4; i++) begin
      drive(8, 1, 0, 0, 0, 0, 0, (i == 0), 1);
      check("dm_freeze", freeze, 1);
      check("dm_sb_hold", byp1, 1);
      adv();
    end
    drive(8, 1, 0, 0, 0, 0, 0, 0, 0);
    check("dm_freeze_tail", freeze, 1);
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("dm_pend_flush", flush, 1);
      check("dm_pend_nofreeze", freeze, 0);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("dm_flush_done", flush, 0);
    adv();

    // Asynchronous reset in the middle of a flush
    drive(0, 0, 0, 0, 9, 1, 0, 0, 0); adv();
    drive(9, 1, 0, 0, 0, 0, 0, 1, 0);
    check("pre_rst_byp1", byp1, 1);
    adv();
    drive(9, 1, 0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_flush", flush, 1);
    rst = 1;
    #1;
    model_reset();
    check("arst_flush", flush, 0);
    check("arst_bubble", idex_bubble, 0);
    check("arst_byp1", byp1, 0);
    @(posedge clk);
    #1 rst = 0;
    drive(9, 1, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_byp1", byp1, 0);
    adv();

    // Random traffic against the model
    dm_left = 0;
    for (int n = 0; n < 600; n++) begin
      int d;
      bit l, w, b, m;
      d = $urandom_range(0, 4);
      l = ($urandom_range(0, 3) == 0);
      w = l | ($urandom_range(0, 1) == 1);
      b = ($urandom_range(0, 15) == 0);
      if (dm_left == 0 && $urandom_range(0, 24) == 0) dm_left = $urandom_range(1, 4);
      m = (dm_left > 0);
      if (dm_left > 0) dm_left--;
      drive($urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 1),
            d, w, l, b, m);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
